apb_vgachargen_bridge: RTL and testbench
========================================

# apb_vgachargen_bridge

APB3 slave that gives the CPU read/write access to the three text-mode memories of the character generator: character map, colour map and writable glyph table. It converts 32-bit APB transfers into the port-A write/read strobes of those BRAMs. Glyph-table writes are done as 128-bit read-modify-write sequences. The block sits directly upstream of the text-mode top and drives its `ch_map_*`, `col_map_*` and `ch_t_rw_*` ports on the system clock.

## Interface
- `ADDR_W`, 16: APB address width; only `paddr_i[15:2]` decoded.
- `MAP_DEPTH`, 2400: character/colour map entries (80×30).
- `GLYPHS`, 128: writable glyph count (128-bit glyphs).

Ports:
- `clk_i` in 1: system clock (same clock as BRAM port A).
- `arstn_i` in 1: reset. One clock; reset is asynchronous and active-low.
- `psel_i`, `penable_i`, `pwrite_i` in 1: APB control.
- `paddr_i` in ADDR_W: byte address.
- `pwdata_i` in 32: write data.
- `prdata_o` out 32: read data.
- `pready_o`, `pslverr_o` out 1: APB response.
- `ch_map_addr_o` out $clog2(MAP_DEPTH): character map address.
- `ch_map_data_o` out 8: character map write data.
- `ch_map_data_i` in 8: character map read data.
- `ch_map_wen_o` out 1: character map write enable.
- `col_map_addr_o`, `col_map_data_o`, `col_map_data_i`, `col_map_wen_o`: same widths and meaning for the colour map.
- `ch_t_rw_addr_o` out $clog2(GLYPHS): glyph index.
- `ch_t_rw_data_o` out 128: glyph write data.
- `ch_t_rw_data_i` in 128: glyph read data.
- `ch_t_rw_wen_o` out 1: glyph write enable.

## Operation
- Address map (region = `paddr_i[15:14]`, word index `idx` = `paddr_i[13:2]`):
  - 0x0000: char map, entry `idx`.
  - 0x4000: colour map, entry `idx`.
  - 0x8000: glyph table; glyph = `idx[8:2]`, word k = `idx[1:0]`.
  - 0xC000: reserved.
- Map entries use data bits [7:0]. Reads return {24'b0, entry}; `pwdata_i[31:8]` is ignored on writes.
- Glyph word k maps to glyph bits [32k+31:32k].
- Error conditions, each giving PSLVERR=1 with no side effect:
  - reserved region;
  - map `idx` ≥ MAP_DEPTH;
  - glyph index ≥ GLYPHS.
- Address, data and direction are latched on the setup cycle (`psel_i & ~penable_i`) while in IDLE.
- FSM states: IDLE, MWR, RADDR, RWAIT, RESP, GWR, ERR.
  - IDLE → ERR on an invalid setup.
  - IDLE → MWR on a map write.
  - IDLE → RADDR on a map read, glyph read or glyph write.
  - MWR: drive the selected `*_wen_o`=1 with address and data; `pready_o`=1; → IDLE.
  - RADDR: BRAM address stable, BRAM samples at the end of this cycle; `pready_o`=0; → RWAIT.
  - RWAIT: read data valid.
    - Reads: capture the selected byte or glyph word into `prdata_o`; → RESP.
    - Glyph writes: capture the 128-bit glyph with word k replaced by `pwdata_i` into the glyph write-data register; → GWR.
  - RESP: `pready_o`=1, `prdata_o` valid; → IDLE.
  - GWR: `ch_t_rw_wen_o`=1 with the merged glyph; `pready_o`=1; → IDLE.
  - ERR: `pready_o`=1, `pslverr_o`=1, `prdata_o`=0; → IDLE.
- `pready_o`, `pslverr_o` and all `*_wen_o` are registered and high for exactly one cycle per transfer.
- At most one `*_wen_o` is high in any cycle.
- Addresses and write data hold their last value outside transfers.
- If `psel_i` drops before `pready_o`, the FSM still finishes its sequence. A glyph write in progress is still committed.
- Reset mid-sequence: the FSM returns to IDLE at once, all strobes drop, and a pending glyph write is not committed.

## Timing
- Reset values: `prdata_o`=0, `pready_o`=0, `pslverr_o`=0, all `*_wen_o`=0, all addresses and write data=0, FSM=IDLE.
- Wait states (access cycles with `pready_o`=0), counted from the first access cycle:
  - map write: 0;
  - error: 0;
  - map read: 2;
  - glyph read: 2;
  - glyph write: 2.
- BRAM read latency is 1 clock from the sampled address.
- Back-to-back: the next setup cycle is accepted in the cycle after `pready_o`=1, with no idle cycle required.
- Glyph-write merge uses the read data from RWAIT. No other agent writes port A, so the RMW is atomic.

## Test plan
- After reset, write 0xAB to 0x0000+4·79: `ch_map_wen_o` pulses once with addr 79 and data 0xAB, 0 wait states. Read back at the same address gives PRDATA=0x000000AB after 2 waits, PSLVERR=0.
- Colour write 0x1F to idx 2399 is accepted. Access to idx 2400 gives PSLVERR=1, PRDATA=0, no `wen` pulse.
- Glyph 5 preloaded with 128'h0 on the model. Write 0xDEADBEEF to word 2 (addr 0x8000+4·(5·4+2)):
  - `ch_t_rw_wen_o` pulses once with addr 5 and data[95:64]=0xDEADBEEF, other bits 0;
  - reading word 2 back returns 0xDEADBEEF, word 1 returns 0.
- Back-to-back map write, glyph write, map read with zero idle cycles: all complete with the correct waits and no overlapping `wen`.
- Assert `arstn_i` during RWAIT of a glyph write: no `ch_t_rw_wen_o` pulse, all outputs at reset values. The next transfer after release completes normally.
- Access to 0xC000 gives PSLVERR=1 with 0 wait states.

Source files
------------

// File: rtl/apb_vgachargen_bridge.sv
// APB3 slave giving the CPU port-A access to the text-mode char map,
// colour map and 128-bit glyph table; glyph writes are done as RMW.
// Ports: clk_i/arstn_i, APB3 slave (psel/penable/pwrite/paddr/pwdata,
// prdata/pready/pslverr), ch_map_*, col_map_*, ch_t_rw_* BRAM port A.
module apb_vgachargen_bridge #(
  parameter int ADDR_W    = 16,
  parameter int MAP_DEPTH = 2400,
  parameter int GLYPHS    = 128
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [ADDR_W-1:0]            paddr_i,
  input  logic [31:0]                  pwdata_i,
  output logic [31:0]                  prdata_o,
  output logic                         pready_o,
  output logic                         pslverr_o,
  output logic [$clog2(MAP_DEPTH)-1:0] ch_map_addr_o,
  output logic [7:0]                   ch_map_data_o,
  input  logic [7:0]                   ch_map_data_i,
  output logic                         ch_map_wen_o,
  output logic [$clog2(MAP_DEPTH)-1:0] col_map_addr_o,
  output logic [7:0]                   col_map_data_o,
  input  logic [7:0]                   col_map_data_i,
  output logic                         col_map_wen_o,
  output logic [$clog2(GLYPHS)-1:0]    ch_t_rw_addr_o,
  output logic [127:0]                 ch_t_rw_data_o,
  input  logic [127:0]                 ch_t_rw_data_i,
  output logic                         ch_t_rw_wen_o
);

  localparam int MAP_AW = $clog2(MAP_DEPTH);
  localparam int GLY_AW = $clog2(GLYPHS);
  localparam logic [12:0] MAP_LIM = 13'(MAP_DEPTH);
  localparam logic [10:0] GLY_LIM = 11'(GLYPHS);

  typedef enum logic [2:0] {
    IDLE, MWR, RADDR, RWAIT, RESP, GWR, ERR
  } state_t;

  typedef enum logic [1:0] {
    T_CH, T_COL, T_GLY, T_NONE
  } tgt_t;

  state_t       state_q;
  state_t       state_d;
  tgt_t         tgt_d;
  tgt_t         tgt_q;
  logic         wr_q;
  logic [1:0]   word_q;
  logic [31:0]  wdata_q;
  logic         setup;
  logic         accept;
  logic [1:0]   region;
  logic [11:0]  idx;
  logic         addr_ok;
  logic         pready_d;
  logic         pslverr_d;
  logic         ch_wen_d;
  logic         col_wen_d;
  logic         gly_wen_d;
  logic [31:0]  rd_word;
  logic [127:0] merged;
  logic         unused;

  assign setup  = psel_i & ~penable_i;
  assign accept = (state_q == IDLE) & setup;
  assign region = paddr_i[15:14];
  assign idx    = paddr_i[13:2];
  assign unused = ^paddr_i[1:0];

  // The glyph check uses the full word index so that
  // high idx bits never alias onto a valid glyph.
  always_comb begin
    tgt_d   = T_NONE;
    addr_ok = 1'b0;
    unique case (1'b1)
      region == 2'd0: begin
        tgt_d   = T_CH;
        addr_ok = {1'b0, idx} < MAP_LIM;
      end
      region == 2'd1: begin
        tgt_d   = T_COL;
        addr_ok = {1'b0, idx} < MAP_LIM;
      end
      region == 2'd2: begin
        tgt_d   = T_GLY;
        addr_ok = {1'b0, idx[11:2]} < GLY_LIM;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_word = 32'd0;
    merged  = ch_t_rw_data_i;
    unique case (tgt_q)
      T_CH:    rd_word = {24'd0, ch_map_data_i};
      T_COL:   rd_word = {24'd0, col_map_data_i};
      T_GLY:   rd_word = ch_t_rw_data_i[32*word_q +: 32];
      default: ;
    endcase
    merged[32*word_q +: 32] = wdata_q;
  end

  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    ch_wen_d  = 1'b0;
    col_wen_d = 1'b0;
    gly_wen_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          if (!addr_ok) begin
            state_d   = ERR;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (pwrite_i && tgt_d != T_GLY) begin
            state_d   = MWR;
            pready_d  = 1'b1;
            ch_wen_d  = (tgt_d == T_CH);
            col_wen_d = (tgt_d == T_COL);
          end else begin
            state_d = RADDR;
          end
        end
      end
      RADDR: state_d = RWAIT;
      RWAIT: begin
        pready_d = 1'b1;
        if (wr_q) begin
          state_d   = GWR;
          gly_wen_d = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      MWR, RESP, GWR, ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q       <= IDLE;
      pready_o      <= 1'b0;
      pslverr_o     <= 1'b0;
      ch_map_wen_o  <= 1'b0;
      col_map_wen_o <= 1'b0;
      ch_t_rw_wen_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      pready_o      <= pready_d;
      pslverr_o     <= pslverr_d;
      ch_map_wen_o  <= ch_wen_d;
      col_map_wen_o <= col_wen_d;
      ch_t_rw_wen_o <= gly_wen_d;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      tgt_q          <= T_NONE;
      wr_q           <= 1'b0;
      word_q         <= 2'd0;
      wdata_q        <= 32'd0;
      prdata_o       <= 32'd0;
      ch_map_addr_o  <= '0;
      ch_map_data_o  <= 8'd0;
      col_map_addr_o <= '0;
      col_map_data_o <= 8'd0;
      ch_t_rw_addr_o <= '0;
      ch_t_rw_data_o <= 128'd0;
    end else begin
      if (accept) begin
        tgt_q   <= tgt_d;
        wr_q    <= pwrite_i;
        word_q  <= idx[1:0];
        wdata_q <= pwdata_i;
        if (!addr_ok) begin
          prdata_o <= 32'd0;
        end else begin
          unique case (tgt_d)
            T_CH: begin
              ch_map_addr_o <= idx[MAP_AW-1:0];
              if (pwrite_i) ch_map_data_o <= pwdata_i[7:0];
            end
            T_COL: begin
              col_map_addr_o <= idx[MAP_AW-1:0];
              if (pwrite_i) col_map_data_o <= pwdata_i[7:0];
            end
            T_GLY: ch_t_rw_addr_o <= idx[GLY_AW+1:2];
            default: ;
          endcase
        end
      end
      if (state_q == RWAIT) begin
        if (wr_q) ch_t_rw_data_o <= merged;
        else      prdata_o       <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_apb_vgachargen_bridge.sv
// Scoreboard bench for apb_vgachargen_bridge: APB stimulus pushes
// expected responses/strobes, a monitor pops and compares them.
module tb_apb_vgachargen_bridge;

  localparam int MAP_DEPTH = 2400;
  localparam int GLYPHS    = 128;

  logic         clk_i = 1'b0;
  logic         arstn_i = 1'b0;
  logic         psel_i = 1'b0;
  logic         penable_i = 1'b0;
  logic         pwrite_i = 1'b0;
  logic [15:0]  paddr_i = 16'd0;
  logic [31:0]  pwdata_i = 32'd0;
  logic [31:0]  prdata_o;
  logic         pready_o;
  logic         pslverr_o;
  logic [11:0]  ch_map_addr_o;
  logic [7:0]   ch_map_data_o;
  logic [7:0]   ch_map_data_i = 8'd0;
  logic         ch_map_wen_o;
  logic [11:0]  col_map_addr_o;
  logic [7:0]   col_map_data_o;
  logic [7:0]   col_map_data_i = 8'd0;
  logic         col_map_wen_o;
  logic [6:0]   ch_t_rw_addr_o;
  logic [127:0] ch_t_rw_data_o;
  logic [127:0] ch_t_rw_data_i = 128'd0;
  logic         ch_t_rw_wen_o;

  apb_vgachargen_bridge #(
    .ADDR_W(16), .MAP_DEPTH(MAP_DEPTH), .GLYPHS(GLYPHS)
  ) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .ch_map_addr_o(ch_map_addr_o), .ch_map_data_o(ch_map_data_o),
    .ch_map_data_i(ch_map_data_i), .ch_map_wen_o(ch_map_wen_o),
    .col_map_addr_o(col_map_addr_o), .col_map_data_o(col_map_data_o),
    .col_map_data_i(col_map_data_i), .col_map_wen_o(col_map_wen_o),
    .ch_t_rw_addr_o(ch_t_rw_addr_o), .ch_t_rw_data_o(ch_t_rw_data_o),
    .ch_t_rw_data_i(ch_t_rw_data_i), .ch_t_rw_wen_o(ch_t_rw_wen_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]   bram_ch  [MAP_DEPTH];
  logic [7:0]   bram_col [MAP_DEPTH];
  logic [127:0] bram_gly [GLYPHS];
  logic [7:0]   ref_ch   [MAP_DEPTH];
  logic [7:0]   ref_col  [MAP_DEPTH];
  logic [127:0] ref_gly  [GLYPHS];

  always @(posedge clk_i) begin
    if (int'(ch_map_addr_o) < MAP_DEPTH) begin
      if (ch_map_wen_o) bram_ch[ch_map_addr_o] <= ch_map_data_o;
      ch_map_data_i <= bram_ch[ch_map_addr_o];
    end
    if (int'(col_map_addr_o) < MAP_DEPTH) begin
      if (col_map_wen_o) bram_col[col_map_addr_o] <= col_map_data_o;
      col_map_data_i <= bram_col[col_map_addr_o];
    end
    if (ch_t_rw_wen_o) bram_gly[ch_t_rw_addr_o] <= ch_t_rw_data_o;
    ch_t_rw_data_i <= bram_gly[ch_t_rw_addr_o];
  end

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
    int          waits;
  } rsp_t;

  typedef struct {
    int           which;
    int           addr;
    logic [127:0] data;
  } wen_t;

  rsp_t rsp_q[$];
  wen_t wen_q[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_prdata"}, prdata_o, 0);
    chk({tag, "_pready"}, pready_o, 0);
    chk({tag, "_pslverr"}, pslverr_o, 0);
    chk({tag, "_wens"}, {ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o}, 0);
    chk({tag, "_ch_addr"}, ch_map_addr_o, 0);
    chk({tag, "_ch_data"}, ch_map_data_o, 0);
    chk({tag, "_col_addr"}, col_map_addr_o, 0);
    chk({tag, "_col_data"}, col_map_data_o, 0);
    chk({tag, "_gly_addr"}, ch_t_rw_addr_o, 0);
    chk({tag, "_gly_data"}, ch_t_rw_data_o, 0);
  endtask

  // Monitor: pops the expectation whenever the DUT answers or strobes.
  initial begin
    int   wcnt;
    int   which;
    rsp_t r;
    wen_t w;
    wcnt = 0;
    forever begin
      @(negedge clk_i);
      if (!arstn_i) begin
        wcnt = 0;
      end else begin
        if (ch_map_wen_o | col_map_wen_o | ch_t_rw_wen_o) begin
          chk("wen_onehot", 128'($onehot({ch_map_wen_o, col_map_wen_o,
              ch_t_rw_wen_o})), 1);
          if (wen_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_wen: ch=%0b col=%0b gly=%0b, none due",
                     ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o);
          end else begin
            w = wen_q.pop_front();
            which = ch_map_wen_o ? 0 : (col_map_wen_o ? 1 : 2);
            chk("wen_sel", which, w.which);
            if (which == 0) begin
              chk("ch_addr", ch_map_addr_o, w.addr);
              chk("ch_data", ch_map_data_o, w.data);
            end else if (which == 1) begin
              chk("col_addr", col_map_addr_o, w.addr);
              chk("col_data", col_map_data_o, w.data);
            end else begin
              chk("gly_addr", ch_t_rw_addr_o, w.addr);
              chk("gly_data", ch_t_rw_data_o, w.data);
            end
          end
        end
        if (pready_o && !(psel_i && penable_i)) begin
          checks++;
          fails++;
          $display("FAIL stray_pready: pready=1 outside access, want 0");
        end
        if (psel_i && penable_i) begin
          if (pready_o) begin
            if (rsp_q.size() == 0) begin
              checks++;
              fails++;
              $display("FAIL unexpected_rsp: pready=1, none due");
            end else begin
              r = rsp_q.pop_front();
              chk("waits", wcnt, r.waits);
              chk("pslverr", pslverr_o, r.err);
              if (r.rd || r.err) chk("prdata", prdata_o, r.data);
            end
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
        if (!psel_i) wcnt = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with the bus idle.
  task automatic apb(input bit wr, input logic [15:0] a,
                     input logic [31:0] d);
    int           rgn;
    int           idx;
    int           g;
    int           k;
    int           n;
    bit           bad;
    logic [127:0] nv;
    rsp_t         r;
    wen_t         w;
    rgn = int'(a) / 16384;
    idx = (int'(a) % 16384) / 4;
    g   = idx / 4;
    k   = idx % 4;
    if (rgn == 3)      bad = 1'b1;
    else if (rgn == 2) bad = (g >= GLYPHS);
    else               bad = (idx >= MAP_DEPTH);
    r.rd    = !wr;
    r.err   = bad;
    r.data  = 32'd0;
    r.waits = (bad || (wr && rgn < 2)) ? 0 : 2;
    if (!bad) begin
      if (rgn == 0) begin
        if (wr) begin
          ref_ch[idx] = d[7:0];
          w = '{0, idx, {120'd0, d[7:0]}};
          wen_q.push_back(w);
        end else begin
          r.data = {24'd0, ref_ch[idx]};
        end
      end else if (rgn == 1) begin
        if (wr) begin
          ref_col[idx] = d[7:0];
          w = '{1, idx, {120'd0, d[7:0]}};
          wen_q.push_back(w);
        end else begin
          r.data = {24'd0, ref_col[idx]};
        end
      end else begin
        nv = ref_gly[g];
        if (wr) begin
          nv[32*k +: 32] = d;
          ref_gly[g] = nv;
          w = '{2, g, nv};
          wen_q.push_back(w);
        end else begin
          r.data = nv[32*k +: 32];
        end
      end
    end
    rsp_q.push_back(r);
    psel_i    = 1'b1;
    penable_i = 1'b0;
    pwrite_i  = wr;
    paddr_i   = a;
    pwdata_i  = d;
    @(posedge clk_i);
    #1;
    penable_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!pready_o && n < 20);
    if (!pready_o) begin
      checks++;
      fails++;
      $display("FAIL timeout: addr %0h no pready in %0d cycles", a, n);
    end
    @(posedge clk_i);
    #1;
    psel_i    = 1'b0;
    penable_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   b;
    logic [127:0] gv;
    logic [15:0]  a;
    int           sel;
    for (int i = 0; i < MAP_DEPTH; i++) begin
      b = 8'($urandom);
      bram_ch[i] <= b;
      ref_ch[i] = b;
      b = 8'($urandom);
      bram_col[i] <= b;
      ref_col[i] = b;
    end
    for (int i = 0; i < GLYPHS; i++) begin
      gv = {$urandom, $urandom, $urandom, $urandom};
      if (i == 5) gv = 128'd0;
      bram_gly[i] <= gv;
      ref_gly[i] = gv;
    end

    repeat (3) @(posedge clk_i);
    #1;
    chk_reset("por");
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    apb(1'b1, 16'(4*79), 32'h1234_56AB);
    apb(1'b0, 16'(4*79), 32'd0);
    apb(1'b1, 16'h4000 + 16'(4*2399), 32'h0000_001F);
    apb(1'b0, 16'h4000 + 16'(4*2399), 32'd0);
    apb(1'b1, 16'h4000 + 16'(4*2400), 32'h55);
    apb(1'b0, 16'h4000 + 16'(4*2400), 32'd0);
    apb(1'b0, 16'(4*2400), 32'd0);
    apb(1'b1, 16'h8000 + 16'(4*22), 32'hDEAD_BEEF);
    apb(1'b0, 16'h8000 + 16'(4*22), 32'd0);
    apb(1'b0, 16'h8000 + 16'(4*21), 32'd0);

    apb(1'b1, 16'(4*5), $urandom);
    apb(1'b1, 16'h8000 + 16'(4*31), $urandom);
    apb(1'b0, 16'(4*5), 32'd0);
    apb(1'b0, 16'h8000 + 16'(4*31), 32'd0);

    apb(1'b1, 16'hC000, 32'hFFFF_FFFF);
    apb(1'b0, 16'hC004, 32'd0);

    // Reset lands in RWAIT of a glyph write; it must not commit.
    psel_i    = 1'b1;
    penable_i = 1'b0;
    pwrite_i  = 1'b1;
    paddr_i   = 16'h8000 + 16'(4*37);
    pwdata_i  = 32'hCAFE_F00D;
    @(posedge clk_i);
    #1;
    penable_i = 1'b1;
    @(posedge clk_i);
    #1;
    arstn_i = 1'b0;
    #1;
    chk_reset("midrst");
    @(posedge clk_i);
    #1;
    psel_i    = 1'b0;
    penable_i = 1'b0;
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    apb(1'b0, 16'h8000 + 16'(4*37), 32'd0);
    apb(1'b1, 16'h8000 + 16'(4*37), 32'h0BAD_CAFE);
    apb(1'b0, 16'h8000 + 16'(4*37), 32'd0);

    for (int t = 0; t < 250; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)
        a = 16'(4 * $urandom_range(0, 2600));
      else if (sel < 7)
        a = 16'h4000 + 16'(4 * $urandom_range(0, 2600));
      else if (sel < 9)
        a = 16'h8000 + 16'(4 * $urandom_range(0, 511));
      else
        a = 16'hC000 + 16'(4 * $urandom_range(0, 4095));
      apb(1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
    end

    repeat (4) @(posedge clk_i);
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("wen_q_empty", wen_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
